// File: rtl/seq_101_frame_tx.sv
// seq_101_frame_tx: serial transmitter that sends a fixed preamble, then the payload
// MSB-first, then an idle gap. Used to drive the 101 sequence detector.
module seq_101_frame_tx #(
  parameter int                DATA_W     = 8,
  parameter int                PRE_W      = 3,
  parameter logic [PRE_W-1:0]  PREAMBLE   = 3'b101,
  parameter int                GAP_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              data_o,
  output logic              bit_vld_o,
  output logic              frame_done_o,
  output logic              busy_o
);
  localparam int TOT = PRE_W + DATA_W;
  localparam int CW  = $clog2(PRE_W > DATA_W ? PRE_W : DATA_W) + 1;
  typedef enum logic [1:0] {IDLE, PRE, PAY, GAP} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      gap_q, gap_d;
  logic [TOT-1:0]  sh_q, sh_d;
  logic            data_q, data_d, vld_q, vld_d, done_q, done_d;
  // Preamble and payload share one shift register; the MSB is always the next bit out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    data_d  = 1'b0;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (valid_i) begin
        state_d = PRE;
        cnt_d   = CW'(1);
        sh_d    = {PREAMBLE, data_i} << 1;
        data_d  = PREAMBLE[PRE_W-1];
        vld_d   = 1'b1;
      end
      PRE: begin
        data_d = sh_q[TOT-1];
        sh_d   = sh_q << 1;
        vld_d  = 1'b1;
        if (cnt_q == CW'(PRE_W)) begin
          state_d = PAY;
          cnt_d   = CW'(1);
          done_d  = (DATA_W == 1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PAY: if (cnt_q == CW'(DATA_W)) begin
        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        cnt_d   = '0;
        gap_d   = 4'd1;
      end else begin
        data_d = sh_q[TOT-1];
        sh_d   = sh_q << 1;
        vld_d  = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        done_d = (cnt_q == CW'(DATA_W - 1));
      end
      GAP: if (gap_q >= 4'(GAP_CYCLES)) state_d = IDLE;
        else gap_d = gap_q + 4'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      data_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end
  assign ready_o      = (state_q == IDLE);
  assign busy_o       = !ready_o;
  assign data_o       = data_q;
  assign bit_vld_o    = vld_q;
  assign frame_done_o = done_q;
endmodule

// File: tb/tb_seq_101_frame_tx.sv
// tb_seq_101_frame_tx: scoreboard-checked bench for the frame transmitter, with a
// behavioural 101 detector on a zero-gap instance and a 1-bit payload instance.
module tb_seq_101_frame_tx;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic v0, rdy0, dat0, bv0, dn0, bsy0;
  logic [7:0] d0;
  logic v1, rdy1, dat1, bv1, dn1, bsy1;
  logic [7:0] d1;
  logic v2, rdy2, dat2, bv2, dn2, bsy2;
  logic [0:0] d2;
  seq_101_frame_tx u0 (.clk_i(clk), .rst_n_i(rst_n), .valid_i(v0), .data_i(d0), .ready_o(rdy0),
    .data_o(dat0), .bit_vld_o(bv0), .frame_done_o(dn0), .busy_o(bsy0));
  seq_101_frame_tx #(.GAP_CYCLES(0)) u1 (.clk_i(clk), .rst_n_i(rst_n), .valid_i(v1), .data_i(d1),
    .ready_o(rdy1), .data_o(dat1), .bit_vld_o(bv1), .frame_done_o(dn1), .busy_o(bsy1));
  seq_101_frame_tx #(.DATA_W(1), .GAP_CYCLES(0)) u2 (.clk_i(clk), .rst_n_i(rst_n), .valid_i(v2),
    .data_i(d2), .ready_o(rdy2), .data_o(dat2), .bit_vld_o(bv2), .frame_done_o(dn2), .busy_o(bsy2));
  int tests = 0, fails = 0;
  logic [1:0] sb[$];
  logic [1:0] e_bit;
  int dets[$];
  int pos = 0;
  logic [1:0] h = 2'b00;
  typedef struct {logic [7:0] d; logic [10:0] bits;} vec_t;
  vec_t tbl[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_frame(input logic [10:0] bits);
    for (int i = 10; i >= 0; i--) sb.push_back({bits[i], i == 0});
  endtask
  task automatic wait_ready0;
    int n = 0;
    while (!rdy0 && n < 50) begin tick; n++; end
    if (!rdy0) chk("ready_timeout", 0, 1);
  endtask
  task automatic drain0;
    int n = 0;
    while ((sb.size() != 0 || !rdy0) && n < 100) begin tick; n++; end
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_ready", rdy0, 1);
  endtask
  task automatic send0(input logic [7:0] d, input logic [10:0] bits);
    wait_ready0;
    v0 = 1'b1;
    d0 = d;
    push_frame(bits);
    tick;
    v0 = 1'b0;
    d0 = ~d;
  endtask
  // Every frame bit from u0 must match the head of the scoreboard.
  always @(negedge clk) if (rst_n) begin
    if (bv0) begin
      if (sb.size() == 0) chk("unexpected_bit", 1, 0);
      else begin
        e_bit = sb.pop_front();
        chk("stream_bit", {dat0, dn0}, e_bit);
      end
    end else chk("idle_quiet", {dat0, dn0}, 0);
    chk("busy_vs_ready", bsy0, !rdy0);
  end
  // Behavioural Mealy 101 detector on u1's line, recording 1-based frame bit positions.
  always @(negedge clk) if (rst_n) begin
    if (bv1) begin
      pos++;
      if ({h, dat1} == 3'b101) dets.push_back(pos);
    end else pos = 0;
    h = {h[0], dat1};
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    tbl[0] = '{8'h5A, 11'b101_0101_1010};
    tbl[1] = '{8'hC3, 11'b101_1100_0011};
    tbl[2] = '{8'h01, 11'b101_0000_0001};
    tbl[3] = '{8'h80, 11'b101_1000_0000};
    tbl[4] = '{8'h96, 11'b101_1001_0110};
    v0 = 0; d0 = 0; v1 = 0; d1 = 0; v2 = 0; d2 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", rdy0, 1);
    chk("rst_busy", bsy0, 0);
    chk("rst_vld", bv0, 0);
    chk("rst_data", dat0, 0);
    chk("rst_done", dn0, 0);
    #2 rst_n = 1'b1;
    tick;
    wait_ready0;
    v0 = 1'b1; d0 = 8'hA5;
    push_frame(11'b101_1010_0101);
    tick;
    v0 = 1'b0; d0 = 8'h00;
    for (int k = 1; k <= 13; k++) begin
      chk("a5_bit_vld", bv0, k <= 11);
      chk("a5_ready_low", rdy0, 0);
      tick;
    end
    chk("a5_ready_n14", rdy0, 1);
    for (int i = 0; i < 5; i++) send0(tbl[i].d, tbl[i].bits);
    drain0;
    wait_ready0;
    v0 = 1'b1; d0 = 8'h00;
    push_frame({3'b101, 8'h00});
    push_frame({3'b101, 8'hFF});
    tick;
    d0 = 8'hFF;
    n = 1;
    while (!rdy0 && n < 30) begin tick; n++; end
    chk("b2b_period", n, 14);
    tick;
    v0 = 1'b0;
    chk("b2b_accepted", rdy0, 0);
    drain0;
    send0(8'h81, {3'b101, 8'h81});
    repeat (5) tick;
    v0 = 1'b1; d0 = 8'h3C;
    chk("busy_ready_low", rdy0, 0);
    tick;
    v0 = 1'b0;
    drain0;
    repeat (4) tick;
    chk("busy_ignored_sb", sb.size(), 0);
    chk("busy_ignored_ready", rdy0, 1);
    send0(8'hF0, {3'b101, 8'hF0});
    repeat (6) tick;
    chk("pre_rst_vld", bv0, 1);
    chk("pre_rst_data", dat0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", bv0, 0);
    chk("async_rst_data", dat0, 0);
    chk("async_rst_ready", rdy0, 1);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick;
    chk("post_rst_ready", rdy0, 1);
    send0(8'h0F, {3'b101, 8'h0F});
    drain0;
    chk("lb_ready", rdy1, 1);
    dets.delete();
    v1 = 1'b1; d1 = 8'h00;
    tick;
    v1 = 1'b0;
    repeat (15) tick;
    chk("lb00_count", dets.size(), 1);
    chk("lb00_pos", dets.size() > 0 ? dets[0] : -1, 3);
    dets.delete();
    v1 = 1'b1; d1 = 8'h40;
    tick;
    v1 = 1'b0;
    repeat (15) tick;
    chk("lb40_count", dets.size(), 2);
    chk("lb40_pos0", dets.size() > 0 ? dets[0] : -1, 3);
    chk("lb40_pos1", dets.size() > 1 ? dets[1] : -1, 5);
    chk("w1_ready", rdy2, 1);
    v2 = 1'b1; d2 = 1'b1;
    tick;
    v2 = 1'b0; d2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("w1_vld", bv2, 1);
      chk("w1_data", dat2, k != 2);
      chk("w1_done", dn2, k == 4);
      tick;
    end
    chk("w1_ready_5th", rdy2, 1);
    chk("w1_vld_off", bv2, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_101_frame_tx.md
Name: seq_101_frame_tx

Overview:
- Serial frame transmitter that produces the bit stream consumed by the 101 Mealy sequence detector.
- Accepts a parallel payload word over a valid/ready handshake. Emits a fixed "101" preamble, then the payload MSB-first at one bit per clock, then an idle gap.
- Sits on the transmit end of the single-bit serial link. Used as the stimulus source for detector loopback checks.

Parameters:
- DATA_W, 8, payload width in bits (legal range 1..32).
- PRE_W, 3, preamble width in bits.
- PREAMBLE, 3'b101, preamble pattern, sent MSB-first.
- GAP_CYCLES, 2, idle cycles after each frame (legal range 0..15).

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- valid_i  input  1  payload offered.
- data_i  input  DATA_W  payload word; sampled only on acceptance.
- ready_o  output  1  transmitter can accept a payload.
- data_o  output  1  serial bit out.
- bit_vld_o  output  1  data_o carries a frame bit this cycle.
- frame_done_o  output  1  one-cycle pulse on the last payload bit.
- busy_o  output  1  frame or gap in progress.

Behaviour:
- Reset is asynchronous and active-low. While rst_n_i=0 and on release:
  - state = IDLE
  - data_o = 0, bit_vld_o = 0, frame_done_o = 0, busy_o = 0
  - ready_o = 1
  - shift register and counters cleared
- State machine: IDLE -> PRE -> PAY -> GAP -> IDLE. When GAP_CYCLES = 0, PAY goes directly to IDLE.
- Outputs are registered, except ready_o = (state == IDLE) and busy_o = !ready_o.
- Acceptance: valid_i && ready_o at rising edge N. Then data_i is latched and state becomes PRE. valid_i is ignored while ready_o = 0; no queuing.
- PRE state: cycles N+1 .. N+PRE_W. data_o = PREAMBLE[PRE_W-1-k] in preamble cycle k; bit_vld_o = 1.
- PAY state: cycles N+PRE_W+1 .. N+PRE_W+DATA_W. data_o = payload MSB-first; bit_vld_o = 1.
- frame_done_o = 1 only in the cycle carrying payload bit 0.
- GAP state: next GAP_CYCLES cycles. data_o = 0, bit_vld_o = 0, busy_o = 1.
- ready_o returns to 1 in cycle N+1+PRE_W+DATA_W+GAP_CYCLES. A new frame can be accepted at that edge; the back-to-back period is PRE_W+DATA_W+GAP_CYCLES+1 cycles.
- data_o = 0 whenever bit_vld_o = 0.
- Counters: bit counter width is clog2(max(PRE_W, DATA_W))+1; gap counter is 4 bits. Neither wraps; each is reloaded on every state entry.
- Reset mid-frame: outputs drop to their reset values immediately (asynchronous). The partial frame is abandoned and never resumed. ready_o = 1 after release.
- Changes to data_i after acceptance have no effect on the frame in flight.

Test Plan:
- Single frame, defaults, 0xA5 accepted at edge N:
  - data_o = 1,0,1,1,0,1,0,0,1,0,1 on cycles N+1..N+11 with bit_vld_o = 1
  - frame_done_o pulses at N+11
  - data_o = 0, bit_vld_o = 0 at N+12..N+13
  - ready_o = 1 at N+14
- Back-to-back, valid_i held high with 0x00 then 0xFF:
  - second accept exactly 14 cycles after the first
  - stream: 101 00000000, two idle cycles, 101 11111111
  - no extra idle cycles between frames
- Busy-time valid_i: pulse valid_i with 0x3C during the payload of a 0x81 frame. The 0x81 frame completes unchanged and 0x3C is never transmitted.
- Reset mid-payload: assert rst_n_i = 0 at payload bit 4 of 0xF0.
  - bit_vld_o = 0 and data_o = 0 without waiting for a clock edge
  - ready_o = 1 after release
  - the next frame, 0x0F, is sent complete and correct
- Loopback into the 101 detector, GAP_CYCLES = 0:
  - payload 0x00 gives exactly one seq_det_o, on the third preamble bit
  - payload 0x40 (stream 1,0,1,0,1,0...) gives two detections, on bit 3 and bit 5 (overlap)
- DATA_W = 1, GAP_CYCLES = 0, payload 1: bit_vld_o high for 4 cycles carrying 1,0,1,1, frame_done_o on the 4th, ready_o = 1 on the 5th.
